// File: rtl/mac_operand_feeder_if.sv
// Host/MAC-side bundle of the operand feeder: buffer write port, run control,
// operand stream handshake and MAC control/status.
interface mac_operand_feeder_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic          wr_en;
    logic [DW-1:0] wr_a;
    logic [DW-1:0] wr_b;
    logic          full;
    logic [AW:0]   count;
    logic          start;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic          op_valid;
    logic          op_ready;
    logic          op_last;
    logic          mac_clr;
    logic          mac_en;
    logic          mac_finish;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  wr_en, wr_a, wr_b, start, op_ready, mac_finish,
        output full, count, a_out, b_out, op_valid, op_last,
               mac_clr, mac_en, busy, done, err
    );

    modport master (
        output wr_en, wr_a, wr_b, start, op_ready, mac_finish,
        input  full, count, a_out, b_out, op_valid, op_last,
               mac_clr, mac_en, busy, done, err
    );
endinterface

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs from the host, then on start clears the MAC and streams
// the pairs into it, waiting for mac_finish (or a timeout) before reporting.
module mac_operand_feeder #(
    parameter int DW      = 4,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    mac_operand_feeder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    logic [DW-1:0] mem_a_q [DEPTH];
    logic [DW-1:0] mem_b_q [DEPTH];

    logic wr_accept;
    logic is_last;
    logic xfer;

    assign wr_accept = (state_q == S_IDLE) && bus.wr_en && !full_q;
    assign is_last   = ({1'b0, rd_ptr_q} == (count_q - (AW+1)'(1)));
    assign xfer      = (state_q == S_STREAM) && bus.op_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        tmo_d    = '0;
        err_d    = err_q;

        if (wr_accept) count_d = count_q + (AW+1)'(1);

        case (state_q)
            S_IDLE: begin
                // count_q excludes a same-cycle write, so an empty buffer errors
                // even if a pair is being written alongside start.
                if (bus.start) begin
                    if (count_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                rd_ptr_d = '0;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                if (xfer) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (is_last) state_d = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                if (bus.mac_finish) begin
                    state_d = S_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                count_d  = '0;
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A dropped write is sticky and outranks the clear done by start.
        if (bus.wr_en && !wr_accept) err_d = 1'b1;

        full_d = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            full_q   <= 1'b0;
            rd_ptr_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            full_q   <= full_d;
            rd_ptr_q <= rd_ptr_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_a_q[count_q[AW-1:0]] <= bus.wr_a;
            mem_b_q[count_q[AW-1:0]] <= bus.wr_b;
        end
    end

    assign bus.op_valid = (state_q == S_STREAM);
    assign bus.op_last  = (state_q == S_STREAM) && is_last;
    assign bus.a_out    = (state_q == S_STREAM) ? mem_a_q[rd_ptr_q] : '0;
    assign bus.b_out    = (state_q == S_STREAM) ? mem_b_q[rd_ptr_q] : '0;
    assign bus.mac_clr  = (state_q == S_CLEAR);
    assign bus.mac_en   = (state_q == S_CLEAR) || (state_q == S_STREAM) ||
                          (state_q == S_WAIT_FIN);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: a scoreboard of written pairs checked as they
// are streamed, a vector table of runs, and hand sequences for the corner cases.
module tb_mac_operand_feeder;
    localparam int DW = 4, DEPTH = 8, AW = 3, TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_operand_feeder_if #(.DW(DW), .AW(AW)) bus ();

    mac_operand_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    typedef struct {
        int         n;
        logic [7:0] stall;
        int         fin_dly;
        bit         fin_in_stream;
        int         exp_cnt;
        bit         exp_full;
        bit         exp_werr;
        int         exp_done;
        bit         exp_err;
    } vec_t;

    pair_t sb[$];
    int    mcount = 0;
    int    n_cmp = 0, n_mis = 0;
    int    n_clr = 0, n_done = 0;
    int    clr0 = 0, done0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every accepted transfer is popped and compared.
    pair_t      pexp;
    logic [3:0] pa, pb;
    logic       pl;
    bit         prev_stall = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (bus.op_valid) begin
                if (prev_stall) begin
                    check("hold_a", bus.a_out, pa);
                    check("hold_b", bus.b_out, pb);
                    check("hold_last", bus.op_last, pl);
                end
                if (bus.op_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        pexp = sb.pop_front();
                        check("stream_a", bus.a_out, pexp.a);
                        check("stream_b", bus.b_out, pexp.b);
                        check("stream_last", bus.op_last, (sb.size() == 0));
                    end
                end
            end else begin
                check("idle_operands", {bus.a_out, bus.b_out, 3'b0, bus.op_last}, 0);
            end
            prev_stall = bus.op_valid && !bus.op_ready;
            pa = bus.a_out; pb = bus.b_out; pl = bus.op_last;
            if (bus.mac_clr) n_clr++;
            if (bus.done) n_done++;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic write_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.wr_en = 1'b1;
        bus.wr_a  = a;
        bus.wr_b  = b;
        if (mcount < DEPTH) begin
            sb.push_back({a, b});
            mcount++;
        end
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Runs from the first STREAM cycle to back in IDLE, then checks the outcome.
    task automatic finish_run(input vec_t v);
        int k = 0, wcyc = 0;
        bit last_xfer = 0, fin_seen = 0;
        while (!last_xfer && k < 64) begin
            bus.op_ready   = !v.stall[k % 8];
            bus.mac_finish = v.fin_in_stream;
            last_xfer = bus.op_valid && bus.op_ready && bus.op_last;
            tick();
            k++;
        end
        bus.op_ready   = 1'b0;
        bus.mac_finish = 1'b0;
        if (!last_xfer) check("stream_bound", 0, 1);
        while (bus.busy && !fin_seen && wcyc < 40) begin
            bus.mac_finish = (wcyc == v.fin_dly);
            fin_seen = (wcyc == v.fin_dly);
            tick();
            wcyc++;
        end
        bus.mac_finish = 1'b0;
        if (fin_seen) begin
            check("done_pulse", bus.done, 1);
            check("done_mac_en", bus.mac_en, 0);
            tick();
        end else begin
            check("tmo_cycles", wcyc, TIMEOUT);
        end
        check("end_busy", bus.busy, 0);
        check("end_done_cnt", n_done - done0, v.exp_done);
        check("end_clr_cnt", n_clr - clr0, 1);
        check("end_err", bus.err, v.exp_err);
        check("end_count", bus.count, 0);
        check("end_sb_empty", sb.size(), 0);
        sb.delete();
        mcount = 0;
    endtask

    task automatic do_run(input vec_t v);
        clr0 = n_clr;
        done0 = n_done;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("run_clr", bus.mac_clr, 1);
        check("run_busy", bus.busy, 1);
        tick();
        finish_run(v);
    endtask

    vec_t vecs[6];
    vec_t hv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wr_en = 0; bus.wr_a = 0; bus.wr_b = 0; bus.start = 0;
        bus.op_ready = 0; bus.mac_finish = 0;

        // Reset state
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.op_valid, 0);
        check("rst_last", bus.op_last, 0);
        check("rst_ops", {bus.a_out, bus.b_out}, 0);
        check("rst_clr_en", {bus.mac_clr, bus.mac_en}, 0);
        check("rst_done_err", {bus.done, bus.err}, 0);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        @(posedge clk); #3 rst = 1'b1;
        tick();

        // Exact latency run with op_ready held high
        write_pair(4'd1, 4'd2);
        write_pair(4'd3, 4'd4);
        write_pair(4'd5, 4'd6);
        check("lat_count", bus.count, 3);
        clr0 = n_clr; done0 = n_done;
        bus.start = 1'b1; bus.op_ready = 1'b1;
        tick(); bus.start = 1'b0;                           // t+1
        check("lat_t1_clr", bus.mac_clr, 1);
        check("lat_t1_valid", bus.op_valid, 0);
        check("lat_t1_en", bus.mac_en, 1);
        tick();                                             // t+2
        check("lat_t2", {bus.op_valid, bus.a_out, bus.b_out, bus.op_last}, {1'b1, 4'd1, 4'd2, 1'b0});
        tick();                                             // t+3
        check("lat_t3", {bus.op_valid, bus.a_out, bus.b_out, bus.op_last}, {1'b1, 4'd3, 4'd4, 1'b0});
        tick();                                             // t+4
        check("lat_t4", {bus.op_valid, bus.a_out, bus.b_out, bus.op_last}, {1'b1, 4'd5, 4'd6, 1'b1});
        tick();                                             // t+5
        bus.op_ready = 1'b0;
        check("lat_t5", {bus.op_valid, bus.mac_en, bus.busy}, 3'b011);
        tick();                                             // t+6
        bus.mac_finish = 1'b1;
        check("lat_t6_done", bus.done, 0);
        tick(); bus.mac_finish = 1'b0;                      // t+7
        check("lat_t7_done", bus.done, 1);
        check("lat_t7_en", bus.mac_en, 0);
        tick();
        check("lat_end", {bus.done, bus.busy, bus.count}, 0);
        check("lat_clr_cnt", n_clr - clr0, 1);
        check("lat_done_cnt", n_done - done0, 1);
        check("lat_sb", sb.size(), 0);
        sb.delete(); mcount = 0;

        // Start on empty buffer, start+write, start ignored during STREAM
        clr0 = n_clr;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("empty_err", bus.err, 1);
        check("empty_busy", bus.busy, 0);
        bus.start = 1'b1; write_pair(4'd9, 4'd10); bus.start = 1'b0;
        check("empty_wr_busy", bus.busy, 0);
        check("empty_wr_count", bus.count, 1);
        tick(); tick();
        check("empty_no_clr", n_clr - clr0, 0);
        write_pair(4'd11, 4'd12);
        clr0 = n_clr; done0 = n_done;
        bus.start = 1'b1; write_pair(4'd13, 4'd14); bus.start = 1'b0;
        check("sw_count", bus.count, 3);
        check("sw_err_clr", bus.err, 0);
        check("sw_clr", bus.mac_clr, 1);
        tick();
        bus.start = 1'b1;
        tick(); tick();
        bus.start = 1'b0;
        check("sw_hold_a", bus.a_out, 9);
        hv = '{n: 3, stall: 8'h00, fin_dly: 2, fin_in_stream: 0, exp_cnt: 3,
               exp_full: 0, exp_werr: 0, exp_done: 1, exp_err: 0};
        finish_run(hv);

        // Asynchronous reset in the middle of streaming
        write_pair(4'd2, 4'd3);
        write_pair(4'd4, 4'd5);
        write_pair(4'd6, 4'd7);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("arst_valid", {bus.op_valid, bus.op_last, bus.a_out, bus.b_out}, 0);
        check("arst_ctl", {bus.mac_clr, bus.mac_en, bus.busy, bus.done, bus.err, bus.full}, 0);
        check("arst_count", bus.count, 0);
        sb.delete(); mcount = 0;
        @(posedge clk); #3 rst = 1'b1;
        tick();
        write_pair(4'd7, 4'd7);
        check("arst_new_count", bus.count, 1);
        hv = '{n: 1, stall: 8'h00, fin_dly: 1, fin_in_stream: 0, exp_cnt: 1,
               exp_full: 0, exp_werr: 0, exp_done: 1, exp_err: 0};
        do_run(hv);

        // Table of runs; the timeout run is last because err is sticky
        vecs[0] = '{n: 3, stall: 8'h00, fin_dly: 1,  fin_in_stream: 0, exp_cnt: 3, exp_full: 0, exp_werr: 0, exp_done: 1, exp_err: 0};
        vecs[1] = '{n: 3, stall: 8'h06, fin_dly: 0,  fin_in_stream: 0, exp_cnt: 3, exp_full: 0, exp_werr: 0, exp_done: 1, exp_err: 0};
        vecs[2] = '{n: 9, stall: 8'h00, fin_dly: 3,  fin_in_stream: 0, exp_cnt: 8, exp_full: 1, exp_werr: 1, exp_done: 1, exp_err: 0};
        vecs[3] = '{n: 5, stall: 8'hAA, fin_dly: 14, fin_in_stream: 1, exp_cnt: 5, exp_full: 0, exp_werr: 0, exp_done: 1, exp_err: 0};
        vecs[4] = '{n: 8, stall: 8'h00, fin_dly: 13, fin_in_stream: 0, exp_cnt: 8, exp_full: 1, exp_werr: 0, exp_done: 1, exp_err: 0};
        vecs[5] = '{n: 1, stall: 8'h00, fin_dly: -1, fin_in_stream: 0, exp_cnt: 1, exp_full: 0, exp_werr: 0, exp_done: 0, exp_err: 1};
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                write_pair(DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)));
            check("vec_count", bus.count, vecs[i].exp_cnt);
            check("vec_full", bus.full, vecs[i].exp_full);
            check("vec_werr", bus.err, vecs[i].exp_werr);
            do_run(vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Upstream stage of the `mac` block.
- Buffers up to DEPTH operand pairs (a, b) written by the host. On `start`, clears the MAC accumulator and streams the pairs into it with a valid/ready handshake.
- Waits for the MAC's `finish`, then reports `done`, or `err` on timeout.
- Decouples operand loading from MAC execution so one run is a single `start` pulse.

Parameters:
- DW, 4, operand width of a and b.
- DEPTH, 8, operand-pair buffer depth (power of two).
- AW, 3, log2(DEPTH).
- TIMEOUT, 15, max cycles to wait for `mac_finish` after the last pair.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  write one pair into the buffer.
- wr_a  in  DW  operand a for the write.
- wr_b  in  DW  operand b for the write.
- full  out  1  count == DEPTH.
- count  out  AW+1  pairs currently buffered.
- start  in  1  begin a run.
- a_out  out  DW  operand a to MAC.
- b_out  out  DW  operand b to MAC.
- op_valid  out  1  a_out/b_out valid.
- op_ready  in  1  MAC accepts the pair.
- op_last  out  1  current pair is the final one of the run.
- mac_clr  out  1  one-cycle accumulator clear.
- mac_en  out  1  MAC enable.
- mac_finish  in  1  MAC result complete.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; count = 0; rd_ptr = 0; timeout counter = 0.
  - All outputs 0: a_out, b_out, op_valid, op_last, mac_clr, mac_en, busy, done, err, full.
  - Reset mid-run aborts immediately and the buffer is treated as empty.
- Buffer writes:
  - A write is accepted only in IDLE with !full. It stores at index count; count increments next edge.
  - wr_en when full or not IDLE: data dropped, err set to 1.
- States: IDLE -> CLEAR -> STREAM -> WAIT_FIN -> DONE -> IDLE.
- IDLE:
  - start with count == 0 (including a same-cycle write's effect not yet visible): err = 1, stay IDLE.
  - start with count > 0: err cleared to 0, go to CLEAR.
  - wr_en and start in the same cycle with count > 0: the write is accepted and included in the run.
- CLEAR:
  - mac_clr = 1 for exactly one cycle; mac_en = 1; rd_ptr = 0; go to STREAM.
- STREAM:
  - Outputs: op_valid = 1; a_out/b_out = buffer[rd_ptr]; op_last = (rd_ptr == count-1); mac_en = 1.
  - A transfer occurs on op_valid & op_ready. After a transfer, rd_ptr increments. After the transfer with op_last = 1, go to WAIT_FIN.
  - Without op_ready, a_out, b_out and op_last hold stable; no timeout applies in STREAM.
  - mac_finish is ignored in STREAM.
- WAIT_FIN:
  - op_valid = 0; a_out = b_out = 0; mac_en = 1; the timeout counter increments each cycle from 0.
  - mac_finish = 1: go to DONE. If mac_finish and timeout expiry coincide, finish wins.
  - Counter reaches TIMEOUT without finish: err = 1, count = 0, go to IDLE (no done).
- DONE:
  - done = 1 for one cycle; mac_en = 0; count = 0; rd_ptr = 0; go to IDLE.
- start is ignored in every state other than IDLE.
- Outputs outside their active states:
  - op_valid and op_last are 0 outside STREAM.
  - a_out = b_out = 0 whenever op_valid = 0.
- busy = 1 in CLEAR, STREAM, WAIT_FIN, DONE.
- full and count are registered values.
- Run latency with op_ready tied high:
  - start at cycle t gives CLEAR at t+1 and the first pair valid at t+2.
  - The last pair of N is valid at t+1+N.
  - done follows one cycle after the cycle mac_finish is sampled.

Test Plan:
- Write pairs (1,2),(3,4),(5,6), count == 3; start with op_ready = 1 -> mac_clr pulses at t+1; pairs at t+2..t+4 in order; op_last only at t+4; mac_finish at t+6 -> done pulse at t+7; count = 0; busy = 0.
- Same 3 pairs, op_ready low for 2 cycles on the 2nd pair -> (3,4) held stable with op_valid = 1 for 3 cycles; no duplicate or skipped pair; err = 0.
- Write 9 pairs with DEPTH = 8 -> full = 1 after the 8th; 9th dropped; err = 1; count = 8. A subsequent start clears err and streams 8 pairs; op_last on pair 8.
- start with count == 0 -> err = 1, busy stays 0, mac_clr never asserted. start during STREAM -> ignored; run unchanged.
- Never assert mac_finish -> after TIMEOUT = 15 cycles in WAIT_FIN: err = 1, busy = 0, no done, count = 0.
- Assert rst = 0 mid-STREAM on the 2nd pair -> all outputs 0 asynchronously; count = 0. After release, a new 1-pair run (7,7) completes normally with done.
